// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment sequence monitor: segment codes,
// the fixed display sequence, FSM encoding and the wrap-around index helpers.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;

  localparam int unsigned SEQ_LEN = 5;
  localparam logic [3:0] SEQ [SEQ_LEN] = '{4'd3, 4'd1, 4'd4, 4'd5, 4'd8};

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  function automatic logic [2:0] fwd_idx(input logic [2:0] p, input int unsigned len);
    if (p == 3'(len - 1)) fwd_idx = 3'd0;
    else                  fwd_idx = p + 3'd1;
  endfunction

  function automatic logic [2:0] bwd_idx(input logic [2:0] p, input int unsigned len);
    if (p == 3'd0) bwd_idx = 3'(len - 1);
    else           bwd_idx = p - 3'd1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-to-digit decoder; also reports whether the digit
// belongs to the display sequence and its index there.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_digit,
  output logic       o_ok,
  output logic       o_in_seq,
  output logic [2:0] o_idx
);

  // Exact-match decode; anything outside the ten codes is illegal
  always_comb begin
    o_ok = 1'b1;
    case (i_seg)
      SEG_0:   o_digit = 4'd0;
      SEG_1:   o_digit = 4'd1;
      SEG_2:   o_digit = 4'd2;
      SEG_3:   o_digit = 4'd3;
      SEG_4:   o_digit = 4'd4;
      SEG_5:   o_digit = 4'd5;
      SEG_6:   o_digit = 4'd6;
      SEG_7:   o_digit = 4'd7;
      SEG_8:   o_digit = 4'd8;
      SEG_9:   o_digit = 4'd9;
      default: begin
        o_digit = 4'd0;
        o_ok    = 1'b0;
      end
    endcase
  end

  // Sequence membership lookup against the ROM
  always_comb begin
    o_in_seq = 1'b0;
    o_idx    = 3'd0;
    for (int k = 0; k < SEQ_LEN; k++) begin
      if (o_ok && (o_digit == SEQ[k])) begin
        o_in_seq = 1'b1;
        o_idx    = 3'(k);
      end else begin
        o_in_seq = o_in_seq;
      end
    end
  end

endmodule

// File: rtl/seg7_sequence_monitor.sv
// Receive-side monitor: decodes HEX0 samples and tracks lock, position and
// direction within the cyclic 3-1-4-5-8 display sequence.
module seg7_sequence_monitor
  import seg7_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int SEQ_LEN = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [6:0]       seg_in,
  input  logic             seg_valid,
  output logic [3:0]       digit,
  output logic             digit_ok,
  output logic [2:0]       pos,
  output logic             dir,
  output logic             locked,
  output logic             illegal,
  output logic             step_err,
  output logic             resync,
  output logic [CNT_W-1:0] step_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic [3:0] w_digit;
  logic       w_ok;
  logic       w_in_seq;
  logic [2:0] w_idx;
  logic [2:0] w_fwd;
  logic [2:0] w_bwd;
  logic [2:0] w_exp;
  logic [2:0] w_opp;

  state_t           r_state;
  logic [3:0]       r_digit;
  logic             r_digit_ok;
  logic [2:0]       r_pos;
  logic             r_dir;
  logic             r_locked;
  logic             r_illegal;
  logic             r_step_err;
  logic             r_resync;
  logic [CNT_W-1:0] r_step_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) sat_inc = v;
    else                    sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  seg7_decode u_decode (
    .i_seg    (seg_in),
    .o_digit  (w_digit),
    .o_ok     (w_ok),
    .o_in_seq (w_in_seq),
    .o_idx    (w_idx)
  );

  assign w_fwd = fwd_idx(r_pos, SEQ_LEN);
  assign w_bwd = bwd_idx(r_pos, SEQ_LEN);
  assign w_exp = r_dir ? w_bwd : w_fwd;
  assign w_opp = r_dir ? w_fwd : w_bwd;

  // Lock FSM with registered outputs; pulses default low every cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_HUNT;
      r_digit    <= 4'd0;
      r_digit_ok <= 1'b0;
      r_pos      <= 3'd0;
      r_dir      <= 1'b0;
      r_locked   <= 1'b0;
      r_illegal  <= 1'b0;
      r_step_err <= 1'b0;
      r_resync   <= 1'b0;
      r_step_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_illegal  <= 1'b0;
      r_step_err <= 1'b0;
      r_resync   <= 1'b0;
      if (seg_valid && !w_ok) begin
        r_digit_ok <= 1'b0;
        r_illegal  <= 1'b1;
        r_state    <= ST_HUNT;
        r_locked   <= 1'b0;
      end else if (seg_valid) begin
        r_digit    <= w_digit;
        r_digit_ok <= 1'b1;
        case (r_state)
          ST_HUNT: begin
            if (w_in_seq) begin
              r_pos   <= w_idx;
              r_state <= ST_CONFIRM;
            end else begin
              r_state <= ST_HUNT;
            end
          end
          ST_CONFIRM: begin
            if (w_in_seq && (w_idx == r_pos)) begin
              r_state <= ST_CONFIRM;
            end else if (w_in_seq && (w_idx == w_fwd)) begin
              r_dir      <= 1'b0;
              r_pos      <= w_fwd;
              r_state    <= ST_LOCKED;
              r_locked   <= 1'b1;
              r_step_cnt <= sat_inc(r_step_cnt);
            end else if (w_in_seq && (w_idx == w_bwd)) begin
              r_dir      <= 1'b1;
              r_pos      <= w_bwd;
              r_state    <= ST_LOCKED;
              r_locked   <= 1'b1;
              r_step_cnt <= sat_inc(r_step_cnt);
            end else if (w_in_seq) begin
              r_pos <= w_idx;
            end else begin
              r_state <= ST_HUNT;
            end
          end
          ST_LOCKED: begin
            if (w_in_seq && (w_idx == r_pos)) begin
              r_state <= ST_LOCKED;
            end else if (w_in_seq && (w_idx == w_exp)) begin
              r_pos      <= w_exp;
              r_step_cnt <= sat_inc(r_step_cnt);
            end else if (w_in_seq && (w_idx == w_opp)) begin
              r_dir      <= ~r_dir;
              r_pos      <= w_opp;
              r_step_cnt <= sat_inc(r_step_cnt);
            end else if (w_in_seq && (w_idx == 3'd0)) begin
              // Display restarted from its first entry
              r_resync <= 1'b1;
              r_pos    <= 3'd0;
            end else begin
              r_step_err <= 1'b1;
              r_err_cnt  <= sat_inc(r_err_cnt);
              r_locked   <= 1'b0;
              if (w_in_seq) begin
                r_pos   <= w_idx;
                r_state <= ST_CONFIRM;
              end else begin
                r_state <= ST_HUNT;
              end
            end
          end
          default: begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end else begin
        r_state <= r_state;
      end
    end
  end

  assign digit    = r_digit;
  assign digit_ok = r_digit_ok;
  assign pos      = r_pos;
  assign dir      = r_dir;
  assign locked   = r_locked;
  assign illegal  = r_illegal;
  assign step_err = r_step_err;
  assign resync   = r_resync;
  assign step_cnt = r_step_cnt;
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_seg7_sequence_monitor.sv
// Directed bench for seg7_sequence_monitor: lock-up, direction switch,
// resync, step error, illegal codes, saturation and async reset.
module tb_seg7_sequence_monitor;

  localparam logic [6:0] C1 = 7'b0000110;
  localparam logic [6:0] C2 = 7'b1011011;
  localparam logic [6:0] C3 = 7'b1001111;
  localparam logic [6:0] C4 = 7'b1100110;
  localparam logic [6:0] C5 = 7'b1101101;
  localparam logic [6:0] C7 = 7'b0000111;
  localparam logic [6:0] C8 = 7'b1111111;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [6:0] seg_in = 7'd0;
  logic       seg_valid = 1'b0;
  logic [3:0] digit;
  logic       digit_ok;
  logic [2:0] pos;
  logic       dir;
  logic       locked;
  logic       illegal;
  logic       step_err;
  logic       resync;
  logic [7:0] step_cnt;
  logic [7:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // {digit, digit_ok, pos, dir, locked, illegal, step_err, resync}
  wire [12:0] obs = {digit, digit_ok, pos, dir, locked, illegal, step_err, resync};

  seg7_sequence_monitor #(.CNT_W(8), .SEQ_LEN(5)) dut (
    .CLK(CLK), .RST(RST), .seg_in(seg_in), .seg_valid(seg_valid),
    .digit(digit), .digit_ok(digit_ok), .pos(pos), .dir(dir), .locked(locked),
    .illegal(illegal), .step_err(step_err), .resync(resync),
    .step_cnt(step_cnt), .err_cnt(err_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic put(input logic [6:0] c);
    seg_in    = c;
    seg_valid = 1'b1;
    @(posedge CLK);
    #1;
    seg_valid = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if ({obs, step_cnt, err_cnt} !== 29'd0) begin
      n_bad++;
      $display("FAIL reset: got %h, want 0", {obs, step_cnt, err_cnt});
    end
    RST = 1'b0;
  endtask

  task automatic test_forward;
    put(C3);
    n_cmp++;
    if (obs !== {4'd3, 1'b1, 3'd0, 1'b0, 1'b0, 3'b000}) begin
      n_bad++; $display("FAIL fwd_confirm: got %b", obs);
    end
    put(C1);
    n_cmp++;
    if (obs !== {4'd1, 1'b1, 3'd1, 1'b0, 1'b1, 3'b000}) begin
      n_bad++; $display("FAIL fwd_lock: got %b", obs);
    end
    put(C4); put(C5); put(C8); put(C3);
    n_cmp++;
    if (obs !== {4'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'b000}) begin
      n_bad++; $display("FAIL fwd_wrap: got %b", obs);
    end
    n_cmp++;
    if (step_cnt !== 8'd5) begin
      n_bad++; $display("FAIL fwd_step_cnt: got %0d want 5", step_cnt);
    end
  endtask

  task automatic test_dir_switch;
    put(C1); put(C4);
    put(C1);
    n_cmp++;
    if (obs !== {4'd1, 1'b1, 3'd1, 1'b1, 1'b1, 3'b000}) begin
      n_bad++; $display("FAIL dir_toggle: got %b", obs);
    end
    put(C3);
    n_cmp++;
    if (obs !== {4'd3, 1'b1, 3'd0, 1'b1, 1'b1, 3'b000}) begin
      n_bad++; $display("FAIL dir_bwd_step: got %b", obs);
    end
    put(C8);
    n_cmp++;
    if (obs !== {4'd8, 1'b1, 3'd4, 1'b1, 1'b1, 3'b000}) begin
      n_bad++; $display("FAIL dir_bwd_wrap: got %b", obs);
    end
    n_cmp++;
    if ({step_cnt, err_cnt} !== {8'd10, 8'd0}) begin
      n_bad++; $display("FAIL dir_counts: got %0d/%0d want 10/0", step_cnt, err_cnt);
    end
  endtask

  task automatic test_resync;
    put(C5);
    put(C3);
    n_cmp++;
    if (obs !== {4'd3, 1'b1, 3'd0, 1'b1, 1'b1, 3'b001}) begin
      n_bad++; $display("FAIL resync_pulse: got %b", obs);
    end
    n_cmp++;
    if ({step_cnt, err_cnt} !== {8'd11, 8'd0}) begin
      n_bad++; $display("FAIL resync_counts: got %0d/%0d want 11/0", step_cnt, err_cnt);
    end
    put(C3);
    n_cmp++;
    if (obs !== {4'd3, 1'b1, 3'd0, 1'b1, 1'b1, 3'b000}) begin
      n_bad++; $display("FAIL resync_hold: got %b", obs);
    end
  endtask

  task automatic test_step_err;
    put(C1);
    n_cmp++;
    if (obs !== {4'd1, 1'b1, 3'd1, 1'b0, 1'b1, 3'b000}) begin
      n_bad++; $display("FAIL err_setup: got %b", obs);
    end
    put(C7);
    n_cmp++;
    if (obs !== {4'd7, 1'b1, 3'd1, 1'b0, 1'b0, 3'b010}) begin
      n_bad++; $display("FAIL err_pulse: got %b", obs);
    end
    n_cmp++;
    if (err_cnt !== 8'd1) begin
      n_bad++; $display("FAIL err_cnt: got %0d want 1", err_cnt);
    end
    put(C2);
    n_cmp++;
    if (obs !== {4'd2, 1'b1, 3'd1, 1'b0, 1'b0, 3'b000}) begin
      n_bad++; $display("FAIL err_hunt_2: got %b", obs);
    end
  endtask

  task automatic test_illegal;
    put(7'b1000001);
    n_cmp++;
    if (obs !== {4'd2, 1'b0, 3'd1, 1'b0, 1'b0, 3'b100}) begin
      n_bad++; $display("FAIL illegal_pulse: got %b", obs);
    end
    seg_in = 7'b1010101;
    @(posedge CLK);
    #1;
    n_cmp++;
    if ({obs, step_cnt, err_cnt} !== {4'd2, 1'b0, 3'd1, 1'b0, 1'b0, 3'b000, 8'd12, 8'd1}) begin
      n_bad++; $display("FAIL invalid_no_change: got %h", {obs, step_cnt, err_cnt});
    end
  endtask

  task automatic test_saturate_async_reset;
    logic [6:0] codes [5];
    codes = '{C3, C1, C4, C5, C8};
    put(C3); put(C1);
    for (int i = 0; i < 260; i++) put(codes[(2 + i) % 5]);
    n_cmp++;
    if ({step_cnt, locked} !== {8'd255, 1'b1}) begin
      n_bad++; $display("FAIL saturate: got %0d lock %b want 255 lock 1", step_cnt, locked);
    end
    #3;
    RST = 1'b1;
    #1;
    n_cmp++;
    if ({obs, step_cnt, err_cnt} !== 29'd0) begin
      n_bad++; $display("FAIL async_reset: got %h want 0", {obs, step_cnt, err_cnt});
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    test_reset;
    test_forward;
    test_dir_switch;
    test_resync;
    test_step_err;
    test_illegal;
    test_saturate_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
